// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style pipeline stages: datapath width,
// PC step, the fetch-buffer entry layout and the bubble instruction.
package arm_pkg;

    localparam int BIT_NUMBER = 32;
    localparam int PC_INCR    = 4;

    localparam logic [BIT_NUMBER-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [BIT_NUMBER-1:0] instruction;
        logic [BIT_NUMBER-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small power-of-two FIFO with push/pop/flush used for both the fetched-word
// buffer and the in-order request address queue of the fetch stage.
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & (count != CNT_W'(DEPTH));
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // Flush wins over any push or pop arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, response buffering
// and branch redirect. Define IF_FETCH_STATS_EN to add fetch/flush counters.
module if_fetch_stage
    import arm_pkg::*;
#(
    parameter int                       BIT_NUMBER = arm_pkg::BIT_NUMBER,
    parameter int                       BUF_DEPTH  = 2,
    parameter logic [BIT_NUMBER-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_addr,
    output logic                  imem_req,
    output logic [BIT_NUMBER-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [BIT_NUMBER-1:0] imem_rdata,
    output logic                  valid,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic [BIT_NUMBER-1:0] pc
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           flush_count
`endif
);

    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int ENTRY_W = 2 * BIT_NUMBER;

    logic [BIT_NUMBER-1:0] fetch_pc;
    logic [BIT_NUMBER-1:0] next_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      data_count;
    logic [CNT_W-1:0]      addr_count;
    logic [CNT_W:0]        credit_used;
    logic [ENTRY_W-1:0]    data_head;
    logic [BIT_NUMBER-1:0] addr_head;
    logic                  rvalid_live;
    logic                  rvalid_keep;
    logic                  data_push;
    logic                  data_pop;

    assign next_pc     = fetch_pc + BIT_NUMBER'(PC_INCR);
    assign credit_used = {1'b0, outstanding} + {1'b0, data_count};
    assign imem_req    = rst & ~branch_taken & (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr   = fetch_pc;

    // A response with nothing outstanding is stale (issued before a reset) and is ignored.
    assign rvalid_live = imem_rvalid & (outstanding != '0);
    assign rvalid_keep = rvalid_live & (discard == '0) & (addr_count != '0);
    assign data_push   = rvalid_keep & ~branch_taken;
    assign data_pop    = valid & ~freeze & ~branch_taken;

    assign valid       = (data_count != '0);
    assign instruction = valid ? data_head[ENTRY_W-1 -: BIT_NUMBER] : BIT_NUMBER'(NOP_INSTR);
    assign pc          = valid ? data_head[BIT_NUMBER-1:0] : '0;

    fetch_buffer #(
        .WIDTH (BIT_NUMBER),
        .DEPTH (BUF_DEPTH)
    ) u_addr_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (imem_req),
        .push_data (next_pc),
        .pop       (rvalid_keep),
        .flush     (branch_taken),
        .count     (addr_count),
        .head      (addr_head)
    );

    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_data_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (data_push),
        .push_data ({imem_rdata, addr_head}),
        .pop       (data_pop),
        .flush     (branch_taken),
        .count     (data_count),
        .head      (data_head)
    );

    // On redirect every request still in flight belongs to the wrong path and must be dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(imem_req) - CNT_W'(rvalid_live);
            if (branch_taken) begin
                fetch_pc <= branch_addr;
                discard  <= outstanding - CNT_W'(rvalid_live);
            end else begin
                if (imem_req) begin
                    fetch_pc <= next_pc;
                end
                if (rvalid_live && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

`ifdef IF_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            fetch_count <= fetch_count + 32'(data_push);
            flush_count <= flush_count + 32'(branch_taken);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage; imem responses are driven
// by hand in each vector so every expected value is computed up front.
module tb_if_fetch_stage;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        freeze       = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr  = '0;
    logic        imem_rvalid  = 1'b0;
    logic [31:0] imem_rdata   = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;
`ifdef IF_FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    typedef struct packed {
        logic        freeze;
        logic        br;
        logic [31:0] baddr;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    if_fetch_stage #(
        .BIT_NUMBER (32),
        .BUF_DEPTH  (2),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .valid        (valid),
        .instruction  (instruction),
        .pc           (pc)
`ifdef IF_FETCH_STATS_EN
        ,
        .fetch_count  (fetch_count),
        .flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic fr, input logic br, input logic [31:0] ba,
                           input logic rv, input logic [31:0] rd,
                           input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] ins, input logic [31:0] pcv);
        vec_t v;
        v.freeze  = fr;
        v.br      = br;
        v.baddr   = ba;
        v.rv      = rv;
        v.rdata   = rd;
        v.e_req   = req;
        v.e_addr  = addr;
        v.e_valid = vld;
        v.e_instr = ins;
        v.e_pc    = pcv;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at a falling edge: drive the row, check the settled outputs, move to the next falling edge.
    task automatic apply_stimulus(input int idx);
        vec_t v;
        v            = vecs[idx];
        freeze       = v.freeze;
        branch_taken = v.br;
        branch_addr  = v.baddr;
        imem_rvalid  = v.rv;
        imem_rdata   = v.rdata;
        #1;
        check_output($sformatf("row%0d imem_req", idx), 32'(imem_req), 32'(v.e_req));
        check_output($sformatf("row%0d imem_addr", idx), imem_addr, v.e_addr);
        check_output($sformatf("row%0d valid", idx), 32'(valid), 32'(v.e_valid));
        check_output($sformatf("row%0d instruction", idx), instruction, v.e_instr);
        check_output($sformatf("row%0d pc", idx), pc, v.e_pc);
        @(negedge clk);
    endtask

    initial begin
        //      fr br baddr         rv rdata          req addr          vld instr          pc
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hE3A01005,  1, 32'h4,         0, 32'h0,         32'h0);
        add_vec(1, 0, 32'h0,        1, 32'hE3A02006,  0, 32'h8,         1, 32'hE3A01005,  32'h4);
        add_vec(1, 0, 32'h0,        0, 32'h0,         0, 32'h8,         1, 32'hE3A01005,  32'h4);
        add_vec(1, 0, 32'h0,        0, 32'h0,         0, 32'h8,         1, 32'hE3A01005,  32'h4);
        add_vec(1, 0, 32'h0,        0, 32'h0,         0, 32'h8,         1, 32'hE3A01005,  32'h4);
        add_vec(0, 0, 32'h0,        0, 32'h0,         0, 32'h8,         1, 32'hE3A01005,  32'h4);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h8,         1, 32'hE3A02006,  32'h8);
        add_vec(0, 0, 32'h0,        1, 32'hE3A03007,  1, 32'hC,         0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hE3A04008,  0, 32'h10,        1, 32'hE3A03007,  32'hC);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h10,        1, 32'hE3A04008,  32'h10);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h14,        0, 32'h0,         32'h0);
        add_vec(0, 1, 32'h100,      0, 32'h0,         0, 32'h18,        0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hDEAD0001,  0, 32'h100,       0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hDEAD0002,  1, 32'h100,       0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hE1A00000,  1, 32'h104,       0, 32'h0,         32'h0);
        add_vec(1, 1, 32'h200,      1, 32'hBAD00000,  0, 32'h108,       1, 32'hE1A00000,  32'h104);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hE2800001,  1, 32'h204,       0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        0, 32'h0,         0, 32'h208,       1, 32'hE2800001,  32'h204);
        add_vec(0, 1, 32'hFFFFFFFC, 0, 32'h0,         0, 32'h208,       0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hDEAD0003,  1, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'hCAFE0001,  0, 32'h4,         0, 32'h0,         32'h0);
        add_vec(1, 0, 32'h0,        0, 32'h0,         0, 32'h4,         1, 32'hCAFE0001,  32'h0);
        // Rows after the mid-run reset: first rvalid is stale and must not be pushed.
        add_vec(0, 0, 32'h0,        1, 32'h55555555,  1, 32'h0,         0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        1, 32'h12345678,  0, 32'h8,         0, 32'h0,         32'h0);
        add_vec(0, 0, 32'h0,        0, 32'h0,         0, 32'h8,         1, 32'h12345678,  32'h4);

        repeat (2) @(negedge clk);
        check_output("reset imem_req", 32'(imem_req), 32'h0);
        check_output("reset valid", 32'(valid), 32'h0);
        check_output("reset instruction", instruction, 32'h0);
        check_output("reset pc", pc, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            apply_stimulus(i);
        end

`ifdef IF_FETCH_STATS_EN
        check_output("stats fetch_count", fetch_count, 32'd7);
        check_output("stats flush_count", flush_count, 32'd3);
`endif

        // Asynchronous reset mid-operation with one fetch still outstanding.
        #2;
        rst          = 1'b0;
        freeze       = 1'b0;
        imem_rvalid  = 1'b0;
        #1;
        check_output("async reset valid", 32'(valid), 32'h0);
        check_output("async reset imem_req", 32'(imem_req), 32'h0);
        check_output("async reset instruction", instruction, 32'h0);
        check_output("async reset pc", pc, 32'h0);
`ifdef IF_FETCH_STATS_EN
        check_output("async reset fetch_count", fetch_count, 32'h0);
        check_output("async reset flush_count", flush_count, 32'h0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 25; i < vecs.size(); i++) begin
            apply_stimulus(i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
